// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word memory behind a valid/ready request/response port with fixed wait states
// Optional DMEM_RANGE_CHECK_EN: addresses at or beyond 4*DEPTH_WORDS fault instead of wrapping.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_idle;
    logic          w_to_resp;
    logic          w_commit;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic [AW-1:0] w_idx;
    logic          w_err;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_rdata_next;

    // With zero wait states the accepting edge is also the RESP-entry edge, so the live request is used.
    assign w_idle    = (r_state == S_IDLE);
    assign w_we      = w_idle ? req_we    : r_we;
    assign w_addr    = w_idle ? req_addr  : r_addr;
    assign w_wdata   = w_idle ? req_wdata : r_wdata;
    assign w_be      = w_idle ? req_be    : r_be;
    assign w_idx     = w_addr[AW+1:2];
    assign w_to_resp = (WAIT_CYCLES == 0) ? (w_idle && req_valid)
                                          : ((r_state == S_WAIT) && (r_wait_cnt == 4'd1));
    assign w_commit  = w_to_resp && reset;

`ifdef DMEM_RANGE_CHECK_EN
    assign w_err = (w_addr[1:0] != 2'b00) || (w_addr >= 32'(4 * DEPTH_WORDS));
`else
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^w_addr[31:AW+2];
    assign w_err = (w_addr[1:0] != 2'b00);
`endif

    assign w_rd_word    = r_mem[w_idx];
    assign w_rdata_next = (w_err || w_we) ? 32'h0 : w_rd_word;

    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_be        <= 4'h0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_be        <= req_be;
                        r_req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rdata_next;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state    <= S_WAIT;
                            r_wait_cnt <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd1) begin
                        r_state     <= S_RESP;
                        r_wait_cnt  <= 4'd0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rdata_next;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - vector table, corner sequences and randomized model check for data_mem_responder
module tb_data_mem_responder;
    localparam int DEPTH = 1024;
    localparam int WC    = 1;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] model_mem [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Starts #1 after a rising edge with the responder idle; ends the same way after the response is taken.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat);
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'b1;
            req_addr  = addr & 32'hFFFF_FFFC;
            req_wdata = $urandom;
            req_be    = 4'hF;
            @(posedge clk); #1;
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", rsp_rdata, rdata);
            check("hold_rsp_err", 32'(rsp_err), 32'(err));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_take", 32'(rsp_valid), 32'd0);
    endtask

    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output logic [31:0] exp_rdata, output logic exp_err);
        int widx;
        logic [31:0] word;
        widx = int'((addr / 4) % DEPTH);
        exp_err = (addr % 4) != 0;
`ifdef DMEM_RANGE_CHECK_EN
        if (addr >= 4 * DEPTH) exp_err = 1'b1;
`endif
        word = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
            model_mem[widx] = word;
        end
        exp_rdata = (we || exp_err) ? 32'h0 : word;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] erd;
        logic        eer;

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_be = 4'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);

        vecs.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h10, 32'h00AA0000, 4'h4, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h3, 32'hDEAABEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0});
`ifdef DMEM_RANGE_CHECK_EN
        vecs.push_back('{1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 32'h1000, 32'h11112222, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0});
`else
        vecs.push_back('{1'b0, 32'h1000, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 32'h1000, 32'h11112222, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0, 32'h0, 4'hF, 32'h11112222, 1'b0});
`endif

        foreach (vecs[k]) begin
            do_txn(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].be, 0, rd, er, lat);
            check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
            check($sformatf("vec%0d_err", k), 32'(er), 32'(vecs[k].exp_err));
            check($sformatf("vec%0d_latency", k), 32'(lat), 32'(WC + 1));
        end

        // Stall in RESP for 5 cycles with stray store requests; memory must be untouched.
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er, lat);
        check("stall_load_rdata", rd, 32'hDEAABEEF);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat);
        check("stall_no_stray_write", rd, 32'hDEAABEEF);

        // Reset during WAIT of a store must drop it.
        do_txn(1'b1, 32'h20, 32'h11111111, 4'hF, 0, rd, er, lat);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAAAAAA; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_rsp_rdata", rsp_rdata, 32'h0);
        check("midreset_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_req_ready", 32'(req_ready), 32'd1);
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
        check("midreset_store_dropped", rd, 32'h11111111);

        for (int w = 0; w < 16; w++) begin
            model_txn(1'b1, 32'(w * 4), 32'h5A000000 + 32'(w), 4'hF, erd, eer);
            do_txn(1'b1, 32'(w * 4), 32'h5A000000 + 32'(w), 4'hF, 0, rd, er, lat);
            check("init_err", 32'(er), 32'(eer));
        end

        for (int t = 0; t < 200; t++) begin
            logic        we;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [3:0]  be;
            addr = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) addr = addr + (32'($urandom_range(1, 255)) << 12);
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            model_txn(we, addr, wdata, be, erd, eer);
            do_txn(we, addr, wdata, be, $urandom_range(0, 2), rd, er, lat);
            check($sformatf("rand%0d_rdata", t), rd, erd);
            check($sformatf("rand%0d_err", t), 32'(er), 32'(eer));
            check($sformatf("rand%0d_latency", t), 32'(lat), 32'(WC + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words stored (power of two, 4 to 65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, giving the number of wait states between accept and response (0 to 15).
REQ-003 SHALL have ports (the codebase's clock/reset names; one clock; reset asynchronous, active-low):
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1=store, 0=load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, lane-aligned.
- req_be  input  4  byte enables, bit i = byte lane i.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator takes the response.
- rsp_rdata  output  32  load data, full word.
- rsp_err  output  1  request faulted.

Function
REQ-004 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-005 SHALL accept a request on a rising edge with req_valid=1 in IDLE, latching we/addr/wdata/be, then move to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-006 SHALL stay in WAIT exactly WAIT_CYCLES cycles via a down-counter loaded at accept, then move to RESP.
REQ-007 SHALL give a fixed latency: rsp_valid first high WAIT_CYCLES+1 cycles after the accepting edge.
REQ-008 SHALL commit stores and capture load data on the edge entering RESP, using word index addr[log2(DEPTH_WORDS)+1:2].
REQ-009 SHALL write only the byte lanes with req_be[i]=1; req_be=0000 on a store SHALL leave memory unchanged with rsp_err=0.
REQ-010 SHALL return the full stored word on loads, ignoring req_be; rsp_rdata SHALL be 0 for stores and faulted requests.
REQ-011 SHALL flag rsp_err=1 and suppress the write when req_addr[1:0]!=00.
REQ-012 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-013 SHALL ignore req_* while not in IDLE; no request is queued, so at most one transaction is outstanding.
REQ-014 SHALL support back-to-back operation: a new request accepts no earlier than the cycle after the RESP->IDLE edge.
REQ-015 SHALL make a load following a store to the same word return the post-store contents.

Reset
REQ-016 SHALL, on reset=0, immediately force IDLE, req_ready=1 (after release), rsp_valid=0, rsp_rdata=0, rsp_err=0 and wait counter=0.
REQ-017 SHALL drop an in-flight transaction on reset mid-operation; a store not yet committed SHALL NOT be written.
REQ-018 SHALL leave memory contents unaffected by reset and uninitialised at power-up.

Configuration
REQ-019 SHALL use macro DMEM_RANGE_CHECK_EN: when defined, any req_addr >= 4*DEPTH_WORDS gives rsp_err=1, no write and rsp_rdata=0; when undefined, upper address bits are ignored (address wraps modulo DEPTH_WORDS) and only REQ-011 can set rsp_err.

Verification
REQ-020 Store addr=0x10, wdata=0xDEADBEEF, be=1111, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid WAIT_CYCLES+1 cycles after each accept.
REQ-021 Memory word 0x10=0xDEADBEEF; store wdata=0x00AA0000, be=0100; load 0x10 -> 0xDEAABEEF.
REQ-022 Load addr=0x13 -> rsp_err=1, rsp_rdata=0; store addr=0x12 -> rsp_err=1, memory unchanged.
REQ-023 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; req_valid pulses during this time ignored.
REQ-024 Assert reset=0 during WAIT of a store to 0x20 (old value 0x11111111) -> outputs at reset values; a later load 0x20 returns 0x11111111.
REQ-025 DEPTH_WORDS=1024, load addr=0x1000: with DMEM_RANGE_CHECK_EN -> rsp_err=1, rsp_rdata=0; without -> returns word 0 contents, rsp_err=0.
